// File: rtl/boot_loader.sv
// boot_loader: framed byte-stream program loader for the pipelined RISC core.
//
// A frame is: SYNC, base[15:0] (LE), count[15:0] (LE), count words of DATA_W/8
// bytes each (LE), then one checksum byte equal to the XOR of every byte between
// SYNC and the checksum. Words are written to memory at base+i. On a good
// checksum the core is released from reset. When the core reports HALTED it is
// held again, so a new program can be loaded without a global reset.
//
// Optional feature (macro BOOT_REG_PRESET_EN): after a good checksum, registers
// 1..NREG-1 are preset to their own index, one per cycle, before the core runs.
// With the macro undefined the reg_* outputs are tied to 0.
//
// Ports:
//   clk1        core clock, rising edge
//   rst_n       asynchronous active-low reset
//   s_valid / s_ready / s_data   byte stream input (transfer on valid & ready)
//   mem_we / mem_addr / mem_wdata   memory write port (one-cycle pulses)
//   reg_we / reg_addr / reg_wdata   register-file write port (preset feature)
//   core_halted  core HALTED flag
//   core_rst_n   core reset, active-low
//   busy         frame in progress (HDR, DATA, CHK, PRESET)
//   err          sticky error: 0 none, 1 checksum, 2 address range
module boot_loader #(
  parameter int         DATA_W = 32,
  parameter int         ADDR_W = 10,
  parameter int         NREG   = 32,
  parameter logic [7:0] SYNC   = 8'hA5
) (
  input  logic                    clk1,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [7:0]              s_data,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic                    reg_we,
  output logic [$clog2(NREG)-1:0] reg_addr,
  output logic [DATA_W-1:0]       reg_wdata,
  input  logic                    core_halted,
  output logic                    core_rst_n,
  output logic                    busy,
  output logic [1:0]              err
);

  localparam int NB   = DATA_W / 8;
  localparam int BW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int RAW  = $clog2(NREG);
  localparam int REMW = 16 + BW + 1;
  localparam logic [16:0] ADDR_LIM = 17'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR    = 3'd1,
    S_DATA   = 3'd2,
    S_CHK    = 3'd3,
    S_RUN    = 3'd4,
`ifdef BOOT_REG_PRESET_EN
    S_PRESET = 3'd6,
`endif
    S_ERR    = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [15:0]       base_r, count_r, widx;
  logic [1:0]        hcnt;
  logic [BW-1:0]     bcnt;
  logic [7:0]        acc;
  logic [DATA_W-1:0] word;
  logic [REMW-1:0]   rem;

  logic              accept;
  logic [15:0]       cnt_in;
  logic              range_bad;
  logic              word_last;
  logic [DATA_W-1:0] word_nxt;

`ifdef BOOT_REG_PRESET_EN
  localparam logic [RAW-1:0] K_LAST = RAW'(NREG - 1);
  logic [RAW-1:0] k;
`endif

  assign accept    = s_valid & s_ready;
  // count high byte arrives on the 4th header byte; base is already complete
  assign cnt_in    = {s_data, count_r[7:0]};
  assign range_bad = ({1'b0, base_r} + {1'b0, cnt_in}) > ADDR_LIM;
  assign word_last = (bcnt == BW'(NB - 1));
  // little-endian assembly: each new byte enters at the top and shifts down
  assign word_nxt  = (word >> 8) | (DATA_W'(s_data) << (DATA_W - 8));

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b1;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept && s_data == SYNC) state_nxt = S_HDR;
      end
      S_HDR: begin
        busy = 1'b1;
        if (accept && hcnt == 2'd3) begin
          if (range_bad)          state_nxt = S_ERR;
          else if (cnt_in == '0)  state_nxt = S_CHK;
          else                    state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        busy = 1'b1;
        if (accept && word_last && widx == count_r - 16'd1) state_nxt = S_CHK;
      end
      S_CHK: begin
        busy = 1'b1;
        if (accept) begin
`ifdef BOOT_REG_PRESET_EN
          state_nxt = (s_data == acc) ? S_PRESET : S_IDLE;
`else
          state_nxt = (s_data == acc) ? S_RUN : S_IDLE;
`endif
        end
      end
`ifdef BOOT_REG_PRESET_EN
      S_PRESET: begin
        busy    = 1'b1;
        s_ready = 1'b0;
        if (k == K_LAST) state_nxt = S_RUN;
      end
`endif
      S_RUN: begin
        s_ready = 1'b0;
        if (core_halted) state_nxt = S_IDLE;
      end
      S_ERR: begin
        // drain the rest of a rejected frame so its payload is not mistaken for SYNC
        if (accept && rem == '0) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      core_rst_n <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      err        <= 2'd0;
      acc        <= 8'h00;
      hcnt       <= 2'd0;
      bcnt       <= '0;
      widx       <= 16'd0;
`ifdef BOOT_REG_PRESET_EN
      k          <= RAW'(1);
`endif
    end else begin
      // registered from next state so the core reset never glitches
      core_rst_n <= (state_nxt == S_RUN);
      mem_we     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept && s_data == SYNC) begin
            err  <= 2'd0;
            acc  <= 8'h00;
            hcnt <= 2'd0;
          end
        end
        S_HDR: begin
          if (accept) begin
            acc  <= acc ^ s_data;
            hcnt <= hcnt + 2'd1;
            widx <= 16'd0;
            bcnt <= '0;
            if (hcnt == 2'd3 && range_bad) err <= 2'd2;
          end
        end
        S_DATA: begin
          if (accept) begin
            acc <= acc ^ s_data;
            if (word_last) begin
              bcnt      <= '0;
              mem_we    <= 1'b1;
              mem_addr  <= base_r[ADDR_W-1:0] + widx[ADDR_W-1:0];
              mem_wdata <= word_nxt;
              widx      <= widx + 16'd1;
            end else begin
              bcnt <= bcnt + BW'(1);
            end
          end
        end
        S_CHK: begin
          if (accept && s_data != acc) err <= 2'd1;
`ifdef BOOT_REG_PRESET_EN
          k <= RAW'(1);
`endif
        end
`ifdef BOOT_REG_PRESET_EN
        S_PRESET: k <= k + RAW'(1);
`endif
        default: ;
      endcase
    end
  end

  // Frame payload holding registers: always loaded before use, so no reset.
  always_ff @(posedge clk1) begin
    if (state == S_HDR && accept) begin
      case (hcnt)
        2'd0:    base_r[7:0]  <= s_data;
        2'd1:    base_r[15:8] <= s_data;
        2'd2:    count_r[7:0] <= s_data;
        default: begin
          count_r[15:8] <= s_data;
          rem           <= REMW'(cnt_in) * REMW'(NB);
        end
      endcase
    end
    if (state == S_DATA && accept) word <= word_nxt;
    if (state == S_ERR && accept)  rem  <= rem - REMW'(1);
  end

`ifdef BOOT_REG_PRESET_EN
  assign reg_we    = (state == S_PRESET);
  assign reg_addr  = k;
  assign reg_wdata = DATA_W'(k);
`else
  assign reg_we    = 1'b0;
  assign reg_addr  = '0;
  assign reg_wdata = '0;
`endif

endmodule
